// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side (datapath) reports memory/hazard events and consumes the
// per-stage enables, flushes, PC write enable and performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNTW = 16
);
    // Hazard and memory events reported by the pipeline
    logic            ihit;
    logic            dhit;
    logic            dmemREN;
    logic            dmemWEN;
    logic            loaduse;
    logic            branch_taken;
    logic            halt_wb;

    // Pipeline register controls
    logic            en_ifid;
    logic            en_idex;
    logic            en_exmem;
    logic            en_memwb;
    logic            fl_ifid;
    logic            fl_idex;
    logic            fl_exmem;
    logic            fl_memwb;
    logic            pc_en;
    logic            halted;

    // Performance visibility
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output ihit, dhit, dmemREN, dmemWEN, loaduse, branch_taken, halt_wb,
        input  en_ifid, en_idex, en_exmem, en_memwb,
        input  fl_ifid, fl_idex, fl_exmem, fl_memwb,
        input  pc_en, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dmemREN, dmemWEN, loaduse, branch_taken, halt_wb,
        output en_ifid, en_idex, en_exmem, en_memwb,
        output fl_ifid, fl_idex, fl_exmem, fl_memwb,
        output pc_en, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Arbitrates halt, data-memory wait, branch redirect, load-use and
// instruction-memory wait into per-stage enable/flush controls and the PC
// write enable. Controls are combinational (zero latency) from state and
// inputs; the squash flag and saturating stall/flush counters are registered.
module pipe_hazard_ctrl #(
    parameter int CNTW = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        logic [CNTW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic            squash_q;
    logic            squash_d;
    logic [CNTW-1:0] stall_q;
    logic [CNTW-1:0] stall_d;
    logic [CNTW-1:0] flush_q;
    logic [CNTW-1:0] flush_d;

    // Ungated control decisions (before reset masking)
    logic en_ifid_s;
    logic en_idex_s;
    logic en_exmem_s;
    logic en_memwb_s;
    logic fl_ifid_s;
    logic fl_idex_s;
    logic fl_exmem_s;
    logic fl_memwb_s;
    logic pc_en_s;
    logic halted_s;
    logic redirect_s;
    logic stall_cyc_s;
    logic dstall_s;

    // A data access that has not completed freezes the whole pipeline.
    assign dstall_s = (hz.dmemREN | hz.dmemWEN) & ~hz.dhit;

    // State, squash flag and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_RUN;
            squash_q <= 1'b0;
            stall_q  <= {CNTW{1'b0}};
            flush_q  <= {CNTW{1'b0}};
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    // Priority arbitration of hazards into stage controls and next state.
    always_comb begin
        en_ifid_s  = 1'b1;
        en_idex_s  = 1'b1;
        en_exmem_s = 1'b1;
        en_memwb_s = 1'b1;
        fl_ifid_s  = 1'b0;
        fl_idex_s  = 1'b0;
        fl_exmem_s = 1'b0;
        fl_memwb_s = 1'b0;
        pc_en_s    = 1'b1;
        halted_s   = 1'b0;
        redirect_s = 1'b0;
        state_d    = state_q;
        squash_d   = squash_q;

        case (state_q)
            ST_RUN: begin
                if (hz.halt_wb) begin
                    // Halt reached WB: freeze everything and park.
                    en_ifid_s  = 1'b0;
                    en_idex_s  = 1'b0;
                    en_exmem_s = 1'b0;
                    en_memwb_s = 1'b0;
                    pc_en_s    = 1'b0;
                    state_d    = ST_HALTED;
                end else if (dstall_s) begin
                    // Full freeze; branch/load-use are re-evaluated once the
                    // access completes because EX/ID contents are held.
                    en_ifid_s  = 1'b0;
                    en_idex_s  = 1'b0;
                    en_exmem_s = 1'b0;
                    en_memwb_s = 1'b0;
                    pc_en_s    = 1'b0;
                end else if (hz.branch_taken) begin
                    // Redirect: kill the two younger instructions, PC loads
                    // the target. A fetch still outstanding was issued for
                    // the old PC and must be discarded when it returns.
                    fl_ifid_s  = 1'b1;
                    fl_idex_s  = 1'b1;
                    redirect_s = 1'b1;
                    squash_d   = ~hz.ihit;
                end else if (hz.loaduse) begin
                    // Hold IF/ID and PC, insert one bubble into ID/EX.
                    en_ifid_s  = 1'b0;
                    fl_idex_s  = 1'b1;
                    pc_en_s    = 1'b0;
                end else if (!hz.ihit) begin
                    // Fetch not ready: bubble into ID, older stages drain.
                    fl_ifid_s  = 1'b1;
                    pc_en_s    = 1'b0;
                end else if (squash_q) begin
                    // Returning fetch belongs to the pre-redirect PC: drop it
                    // and keep the PC at the target so it is refetched.
                    fl_ifid_s  = 1'b1;
                    pc_en_s    = 1'b0;
                    squash_d   = 1'b0;
                end else begin
                    // Normal advance (defaults).
                    pc_en_s    = 1'b1;
                end
            end
            ST_HALTED: begin
                en_ifid_s  = 1'b0;
                en_idex_s  = 1'b0;
                en_exmem_s = 1'b0;
                en_memwb_s = 1'b0;
                pc_en_s    = 1'b0;
                halted_s   = 1'b1;
                state_d    = ST_HALTED;
            end
            default: begin
                en_ifid_s  = 1'b0;
                en_idex_s  = 1'b0;
                en_exmem_s = 1'b0;
                en_memwb_s = 1'b0;
                pc_en_s    = 1'b0;
                state_d    = ST_RUN;
                squash_d   = 1'b0;
            end
        endcase
    end

    // Stall cycles are RUN cycles where the PC does not advance.
    assign stall_cyc_s = (state_q == ST_RUN) & ~pc_en_s;

    // Saturating performance counter updates.
    always_comb begin
        if (stall_cyc_s) begin
            stall_d = sat_inc(stall_q);
        end else begin
            stall_d = stall_q;
        end
        if (redirect_s) begin
            flush_d = sat_inc(flush_q);
        end else begin
            flush_d = flush_q;
        end
    end

    // Force every control low while reset is held so nothing moves.
    always_comb begin
        if (RST) begin
            hz.en_ifid  = 1'b0;
            hz.en_idex  = 1'b0;
            hz.en_exmem = 1'b0;
            hz.en_memwb = 1'b0;
            hz.fl_ifid  = 1'b0;
            hz.fl_idex  = 1'b0;
            hz.fl_exmem = 1'b0;
            hz.fl_memwb = 1'b0;
            hz.pc_en    = 1'b0;
            hz.halted   = 1'b0;
        end else begin
            hz.en_ifid  = en_ifid_s;
            hz.en_idex  = en_idex_s;
            hz.en_exmem = en_exmem_s;
            hz.en_memwb = en_memwb_s;
            hz.fl_ifid  = fl_ifid_s;
            hz.fl_idex  = fl_idex_s;
            hz.fl_exmem = fl_exmem_s;
            hz.fl_memwb = fl_memwb_s;
            hz.pc_en    = pc_en_s;
            hz.halted   = halted_s;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the per-stage EN and flush controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Arbitrates data-memory wait, branch redirect, load-use, instruction-memory wait and halt.
- Tracks an in-flight wrong-path fetch that must be squashed when it returns.
- Keeps saturating stall and flush counters for performance visibility.

Parameters:
CNTW, 16, width of stall_cnt and flush_cnt (saturating).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous reset, active-high.
ihit  in  1  instruction memory returns valid instruction this cycle.
dhit  in  1  data memory completes MEM-stage access this cycle.
dmemREN  in  1  MEM-stage load request.
dmemWEN  in  1  MEM-stage store request.
loaduse  in  1  ID-stage instruction depends on EX-stage load.
branch_taken  in  1  EX stage resolved redirect (taken branch/jump).
halt_wb  in  1  halt instruction in WB stage.
en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register enables.
fl_ifid, fl_idex, fl_exmem, fl_memwb  out  1 each  register flushes (flush overrides EN at the register).
pc_en  out  1  PC register write enable.
halted  out  1  sticky halt indicator.
stall_cnt  out  CNTW  cycles in RUN with pc_en=0.
flush_cnt  out  CNTW  accepted branch redirects.

Behaviour:
- State: FSM {RUN, HALTED}, squash_pend flag, two counters. Control outputs are combinational from state, squash_pend and inputs (zero latency); counters are registered.
- RST asserted (async): state=RUN, squash_pend=0, counters=0. While RST=1, all en/fl/pc_en/halted = 0.
- HALTED: all en=0, fl=0, pc_en=0, halted=1. Leaves only on RST.
- RUN priority, highest first, one case per cycle. Unlisted en=1 and fl=0.
  1. halt_wb=1: all en=0, fl=0, pc_en=0. Next state HALTED.
  2. dstall = (dmemREN|dmemWEN)&!dhit: all en=0, all fl=0, pc_en=0 (full freeze). branch_taken and loaduse are ignored and re-evaluated next cycle; the EX/ID contents are held.
  3. branch_taken: fl_ifid=1, fl_idex=1, pc_en=1 (PC takes target). flush_cnt++. If ihit=0 the fetch in flight is wrong-path: set squash_pend=1. If ihit=1, squash_pend is cleared.
  4. loaduse: en_ifid=0, pc_en=0, fl_idex=1 (one bubble). EX/MEM and MEM/WB advance. squash_pend unchanged.
  5. ihit=0: fl_ifid=1 (bubble), pc_en=0. Later stages advance.
  6. ihit=1 and squash_pend=1: fl_ifid=1, pc_en=0 (PC holds target for refetch). Clear squash_pend.
  7. ihit=1, squash_pend=0: all en=1, fl=0, pc_en=1.
- Never assert fl_x together with a required hold of the same register. A flush is only issued where a bubble or squash is intended.
- Instruction memory latches its request address, so a response after a redirect belongs to the old PC. This is why squash_pend exists.
- stall_cnt increments on any RUN cycle (RST=0) with pc_en=0, including case 1. flush_cnt increments on case 3. Both saturate at all-ones with no wrap.
- RST mid-stall or mid-squash discards squash_pend and counters immediately.

Test Plan:
- Reset then idle with ihit=1 and other inputs 0 -> all en=1, fl=0, pc_en=1, counters stay 0 for 10 cycles; RST pulse mid-run -> all outputs 0 at once, counters 0.
- dmemREN=1 with dhit=0 for 3 cycles, branch_taken=1 and loaduse=1 held throughout -> all en/fl/pc_en=0 for 3 cycles, stall_cnt=3, flush_cnt=0; dhit=1 on cycle 4 -> branch case applies (fl_ifid=fl_idex=1, pc_en=1), flush_cnt=1.
- loaduse=1 for one cycle with ihit=1 -> en_ifid=0, pc_en=0, fl_idex=1, en_exmem=en_memwb=1; stall_cnt +1.
- branch_taken=1 with ihit=0, then ihit=0 for 2 cycles, then ihit=1 -> squash_pend set; bubbles for 2 cycles; on the ihit cycle fl_ifid=1, pc_en=0, squash_pend cleared; following ihit=1 cycle gives normal advance.
- halt_wb=1 while dstall is active -> freeze that cycle, HALTED next, halted=1 held for 20 cycles regardless of inputs; only RST clears it.
- CNTW=4, hold ihit=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
